// File: rtl/seq_const_pkg.sv
// rtl/seq_const_pkg.sv - opcodes and FSM state encoding for sequenciador_constantes
package seq_const_pkg;

  localparam logic [1:0] OP_LOADLIT = 2'b00;
  localparam logic [1:0] OP_LCL     = 2'b01;
  localparam logic [1:0] OP_LCH     = 2'b10;
  localparam logic [1:0] OP_JUMP    = 2'b11;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    EXTENSAO = 3'd1,
    LEITURA  = 3'd2,
    ESPERA   = 3'd3,
    ESCRITA  = 3'd4
  } estado_t;

endpackage

// File: rtl/sequenciador_constantes_extensor.sv
// rtl/sequenciador_constantes_extensor.sv - sign extender: 16-bit immediate, or 12-bit jump offset
module Extensor (
  input  logic        controle_i,
  input  logic [15:0] imediato_i,
  output logic [31:0] saida_o
);

  always_comb begin
    saida_o = {{16{imediato_i[15]}}, imediato_i};
    if (controle_i) begin
      saida_o = {{20{imediato_i[11]}}, imediato_i[11:0]};
    end
  end

endmodule

// File: rtl/sequenciador_constantes.sv
// rtl/sequenciador_constantes.sv - multi-cycle controller for loadlit/lcl/lch/jump
// Optional build macro SEQ_LINK_EN: jump also writes PC+1 into register 31.
module sequenciador_constantes
  import seq_const_pkg::*;
#(
  parameter int END_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Opcode,
  input  logic [15:0]      Imediato,
  input  logic [END_W-1:0] RegDest,
  input  logic [31:0]      PC,
  output logic             Ocupado,
  output logic             Pronto,
  output logic             RegLeEn,
  output logic [END_W-1:0] RegLeEnd,
  input  logic [31:0]      RegLeDado,
  output logic             RegEscEn,
  output logic [END_W-1:0] RegEscEnd,
  output logic [31:0]      RegEscDado,
  output logic             PCEscEn,
  output logic [31:0]      PCNovo
);

  estado_t          estado_q;
  logic [1:0]       op_q;
  logic [15:0]      imm_q;
  logic [END_W-1:0] dest_q;
  logic [31:0]      pc_q;

  logic             ocupado_q;
  logic             pronto_q;
  logic             reg_le_en_q;
  logic             reg_esc_en_q;
  logic [END_W-1:0] reg_esc_end_q;
  logic [31:0]      reg_esc_dado_q;
  logic             pc_esc_en_q;
  logic [31:0]      pc_novo_q;

  logic [31:0]      ext_saida;

  Extensor u_extensor (
    .controle_i (op_q == OP_JUMP),
    .imediato_i (imm_q),
    .saida_o    (ext_saida)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q       <= OCIOSO;
      op_q           <= OP_LOADLIT;
      imm_q          <= '0;
      dest_q         <= '0;
      pc_q           <= '0;
      ocupado_q      <= 1'b0;
      pronto_q       <= 1'b0;
      reg_le_en_q    <= 1'b0;
      reg_esc_en_q   <= 1'b0;
      reg_esc_end_q  <= '0;
      reg_esc_dado_q <= '0;
      pc_esc_en_q    <= 1'b0;
      pc_novo_q      <= '0;
    end else begin
      // Strobes are single-cycle; only the transition into a state raises them.
      pronto_q     <= 1'b0;
      reg_le_en_q  <= 1'b0;
      reg_esc_en_q <= 1'b0;
      pc_esc_en_q  <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (Start) begin
            op_q      <= Opcode;
            imm_q     <= Imediato;
            dest_q    <= RegDest;
            pc_q      <= PC;
            ocupado_q <= 1'b1;
            if (Opcode == OP_LCL || Opcode == OP_LCH) begin
              estado_q    <= LEITURA;
              reg_le_en_q <= 1'b1;
            end else begin
              estado_q <= EXTENSAO;
            end
          end
        end
        EXTENSAO: begin
          estado_q <= ESCRITA;
          pronto_q <= 1'b1;
          if (op_q == OP_JUMP) begin
            pc_esc_en_q <= 1'b1;
            pc_novo_q   <= pc_q + ext_saida;
`ifdef SEQ_LINK_EN
            reg_esc_en_q   <= 1'b1;
            reg_esc_end_q  <= END_W'(31);
            reg_esc_dado_q <= pc_q + 32'd1;
`else
`endif
          end else begin
            reg_esc_en_q   <= 1'b1;
            reg_esc_end_q  <= dest_q;
            reg_esc_dado_q <= ext_saida;
          end
        end
        LEITURA: begin
          estado_q <= ESPERA;
        end
        ESPERA: begin
          // RegLeDado is valid now, one cycle after the read request.
          estado_q       <= ESCRITA;
          pronto_q       <= 1'b1;
          reg_esc_en_q   <= 1'b1;
          reg_esc_end_q  <= dest_q;
          reg_esc_dado_q <= (op_q == OP_LCL) ? {RegLeDado[31:16], imm_q}
                                             : {imm_q, RegLeDado[15:0]};
        end
        ESCRITA: begin
          estado_q  <= OCIOSO;
          ocupado_q <= 1'b0;
        end
        default: begin
          estado_q  <= OCIOSO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign Ocupado    = ocupado_q;
  assign Pronto     = pronto_q;
  assign RegLeEn    = reg_le_en_q;
  assign RegLeEnd   = dest_q;
  assign RegEscEn   = reg_esc_en_q;
  assign RegEscEnd  = reg_esc_end_q;
  assign RegEscDado = reg_esc_dado_q;
  assign PCEscEn    = pc_esc_en_q;
  assign PCNovo     = pc_novo_q;

endmodule
